vdc_ram_arbiter: RTL and testbench
==================================

// Module: vdc_ram_arbiter
// PURPOSE
//  Per-character-slot owner of the VDC video RAM port. Arbitrates one RAM access per column slot
//  among five requesters (char fetch, refresh, screen fetch, attribute fetch, CPU/block engine).
//  Sequences the issue (newCol) / capture (endCol) pair and runs power-on RAM init.
//  Sits between the fetch/CPU logic and vdcram; it replaces the ad-hoc if/else slot chain.
// PARAMETERS
//  NREQ         5    number of requesters; index = priority, 0 highest (fixed by vdc_pkg)
//  ADDR_BITS    16   logical VDC address width; address shuffling stays downstream
//  STARVE_LIMIT 0    CPU denied-slot count that forces a CPU grant; 0 = guard disabled
// PORTS
//  clk        in  1          system clock
//  reset      in  1          synchronous, active-high
//  enable     in  1          VDC clock enable; newCol/endCol qualify only when high
//  newCol     in  1          slot start: arbitrate and issue
//  endCol     in  1          slot end: capture ram_do, signal completion
//  initRam    in  1          sampled in reset: 1 = run init sweep after reset
//  win_int    in  1          interrupt/blanking window: SCRN and ATTR masked
//  win_rfsh   in  1          refresh window: RFSH allowed only when high
//  req        in  NREQ       per-requester request level, held until done
//  req_we     in  NREQ       1 = write, 0 = read
//  req_addr   in  NREQ x 16  per-requester address
//  req_wdata  in  NREQ x 8   per-requester write data
//  grant      out NREQ       one-hot owner of the current slot, held newCol..endCol
//  done       out NREQ       one-clk pulse at endCol for the owning requester
//  rdata      out 8          ram_do captured at endCol; valid with done
//  ram_rd     out 1          one-clk read strobe to vdcram
//  ram_we     out 1          one-clk write strobe to vdcram
//  ram_addr   out 16         RAM address
//  ram_di     out 8          RAM write data
//  ram_do     in  8          RAM read data
//  init_busy  out 1          high from reset through the end of the init sweep
// BEHAVIOUR
//  Reset: grant=0, done=0, rdata=0, ram_rd=ram_we=0, ram_addr=16'hFFFF, ram_di=0, starve=0;
//   init_busy=1 while reset is high. State <= INIT if initRam, else IDLE.
//  States: INIT -> IDLE <-> ISSUED.
//  INIT: one write per clk, independent of enable. Data is FF at even addresses, 00 at odd,
//   from addr 0 to FFFF. After the write to FFFF: init_busy=0, ram_addr=FFFF, go to IDLE.
//   Requests are ignored in INIT.
//  IDLE and ISSUED on enable&&newCol: build a mask. RFSH needs win_rfsh&!win_int.
//   SCRN and ATTR need !win_int. CHAR and CPU are never masked.
//   Grant the lowest set index of req&mask. Drive ram_addr/ram_di/ram_rd|ram_we from the
//   winner for 1 clk, set grant, go to ISSUED.
//   No winner: dummy read of 16'hFFFF, grant=0, go to ISSUED.
//  ISSUED on enable&&endCol: rdata<=ram_do (also for writes), done<=grant for 1 clk,
//   grant<=0, go to IDLE.
//   newCol in ISSUED without a preceding endCol: the open slot is abandoned, no done is
//   issued, and arbitration restarts.
//  newCol and endCol high in the same clk: endCol is processed first, then the new issue.
//   done and the new grant are both asserted in that clk.
//  Starvation guard (STARVE_LIMIT>0): 8-bit counter increments when CPU req is denied a slot.
//   It saturates at 255 and clears when CPU is granted.
//   counter>=STARVE_LIMIT forces a CPU grant unless CHAR requests.
//  Requester rule: a requester may drop req only after its done. Its address and data are
//   sampled at newCol only.
//  reset mid-slot: grant, done and strobes clear in the same clk; there is no completion.
//  Write data is driven only on write slots. On other slots ram_di holds its previous value.
// CONFIGURATION
//  VDC_ARB_STATS_EN defined: per-requester 16-bit saturating grant counters, plus idle-slot
//   counter. Counters are snapshotted to stat_cnt[NREQ+1] outputs and cleared on a stat_clr
//   input pulse (driven with fetchFrame). Both ports exist only under the macro.
//  VDC_ARB_STATS_EN undefined: no counters and no stat ports; arbitration is identical.
// STRUCTURE
//  vdc_pkg: typedef enum {REQ_CHAR=0, REQ_RFSH, REQ_SCRN, REQ_ATTR, REQ_CPU} vdcReq_t;
//   NREQ localparam; arbState_t {ARB_INIT, ARB_IDLE, ARB_ISSUED}; INIT_EVEN/ODD constants.
//  Sub-module vdc_arb_stats: the counter bank, instantiated only under VDC_ARB_STATS_EN.
//  Mask and priority encoding stay inline.
// TESTING
//  1 initRam=1 reset -> 65536 consecutive writes, with addr0=FF, addr1=00 and FFFF=00.
//    init_busy falls the clk after the FFFF write; no grant occurs during INIT.
//  2 req=CHAR|SCRN|CPU, win_int=0, one newCol -> grant=00001, ram_rd=1.
//    endCol -> done=00001 and rdata=ram_do.
//  3 req=SCRN|ATTR, win_int=1 -> dummy read of FFFF with grant=0.
//    Same with req=CPU, win_int=1 -> grant=CPU.
//  4 req=RFSH|SCRN: win_rfsh=1 -> RFSH granted; win_rfsh=0 -> SCRN granted.
//  5 STARVE_LIMIT=3, SCRN+CPU requested continuously -> 3 SCRN slots, then 1 CPU slot.
//    With CHAR also requested, CPU is never forced.
//  6 Reset asserted between newCol and endCol -> no done pulse; all outputs at reset values next clk.

Source files
------------

// File: rtl/vdc_pkg.sv
// -----------------------------------------------------------------------------
// vdc_pkg
// Shared types and constants for the VDC video-RAM arbiter slice.
//   NREQ        : number of RAM requesters; the requester index is its priority
//                 (0 = highest).
//   vdcReq_t    : requester indices (char, refresh, screen, attribute, CPU).
//   arbState_t  : arbiter states INIT -> IDLE <-> ISSUED.
//   INIT_EVEN/ODD : data written by the power-on RAM sweep.
//   init_data() : sweep data for a given address LSB.
// Optional feature macro used by the arbiter: VDC_ARB_STATS_EN.
// -----------------------------------------------------------------------------
package vdc_pkg;

    localparam int NREQ  = 5;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        REQ_CHAR = 3'd0,
        REQ_RFSH = 3'd1,
        REQ_SCRN = 3'd2,
        REQ_ATTR = 3'd3,
        REQ_CPU  = 3'd4
    } vdcReq_t;

    typedef enum logic [1:0] {
        ARB_INIT   = 2'd0,
        ARB_IDLE   = 2'd1,
        ARB_ISSUED = 2'd2
    } arbState_t;

    localparam logic [7:0] INIT_EVEN  = 8'hFF;
    localparam logic [7:0] INIT_ODD   = 8'h00;
    localparam logic [7:0] STARVE_MAX = 8'hFF;

    // Power-on sweep pattern: FF at even addresses, 00 at odd addresses.
    function automatic logic [7:0] init_data(input logic addr_lsb);
        return addr_lsb ? INIT_ODD : INIT_EVEN;
    endfunction

endpackage

// File: rtl/vdc_arb_stats.sv
// -----------------------------------------------------------------------------
// vdc_arb_stats
// Slot statistics bank for the VDC RAM arbiter (only built when the arbiter is
// compiled with VDC_ARB_STATS_EN). One 16-bit saturating counter per requester
// counts granted slots; counter [NREQ] counts slots with no winner. A clear
// pulse snapshots all counters to o_cnt and restarts counting.
//   clk, reset  : clock, synchronous active-high reset
//   i_clr       : snapshot-and-clear pulse (driven with fetchFrame)
//   i_slot      : one-clk pulse per arbitrated slot
//   i_grant_oh  : one-hot winner of that slot (all zero = idle slot)
//   o_cnt       : snapshot of the counters, [NREQ] = idle-slot count
// -----------------------------------------------------------------------------
module vdc_arb_stats
    import vdc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clr,
    input  logic                  i_slot,
    input  logic [NREQ-1:0]       i_grant_oh,
    output logic [NREQ:0][15:0]   o_cnt
);

    logic [NREQ:0]        w_evt;
    logic [NREQ:0][15:0]  r_cnt;
    logic [NREQ:0][15:0]  r_snap;

    assign w_evt = i_slot ? {~(|i_grant_oh), i_grant_oh} : {(NREQ+1){1'b0}};

    // Saturating slot counters with snapshot-and-clear; a slot coinciding with the clear starts the new period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_snap <= '0;
        end else begin
            for (int i = 0; i <= NREQ; i++) begin
                if (i_clr) begin
                    r_cnt[i] <= {15'd0, w_evt[i]};
                end else if (w_evt[i] && (r_cnt[i] != 16'hFFFF)) begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
            if (i_clr) begin
                r_snap <= r_cnt;
            end else begin
                r_snap <= r_snap;
            end
        end
    end

    assign o_cnt = r_snap;

endmodule

// File: rtl/vdc_ram_arbiter.sv
// -----------------------------------------------------------------------------
// vdc_ram_arbiter
// Owns the VDC video-RAM port: one access per character slot, chosen among
// five requesters by fixed priority (index 0 highest) with window masking and
// an optional CPU starvation guard. newCol issues the winner's access, endCol
// captures ram_do and pulses done for the owner. After reset with initRam high
// it first sweeps the whole RAM (FF even / 00 odd) at one write per clock.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   enable                : VDC clock enable qualifying newCol/endCol
//   newCol, endCol        : slot start (arbitrate+issue) / slot end (capture)
//   initRam               : sampled during reset, 1 = run init sweep
//   win_int, win_rfsh     : blanking window (masks SCRN/ATTR/RFSH), refresh window
//   req/req_we/req_addr/req_wdata : per-requester request, direction, address, data
//   grant, done, rdata    : slot owner, completion pulse, captured read data
//   ram_rd, ram_we, ram_addr, ram_di, ram_do : vdcram interface
//   init_busy             : high from reset through the end of the init sweep
//   stat_clr, stat_cnt    : statistics clear/snapshot (VDC_ARB_STATS_EN only)
// Parameters: ADDR_BITS (address width), STARVE_LIMIT (0 disables the guard).
// -----------------------------------------------------------------------------
module vdc_ram_arbiter
    import vdc_pkg::*;
#(
    parameter int          ADDR_BITS    = 16,
    parameter int unsigned STARVE_LIMIT = 0
)
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            newCol,
    input  logic                            endCol,
    input  logic                            initRam,
    input  logic                            win_int,
    input  logic                            win_rfsh,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ-1:0]                 req_we,
    input  logic [NREQ-1:0][ADDR_BITS-1:0]  req_addr,
    input  logic [NREQ-1:0][7:0]            req_wdata,
    output logic [NREQ-1:0]                 grant,
    output logic [NREQ-1:0]                 done,
    output logic [7:0]                      rdata,
    output logic                            ram_rd,
    output logic                            ram_we,
    output logic [ADDR_BITS-1:0]            ram_addr,
    output logic [7:0]                      ram_di,
    input  logic [7:0]                      ram_do,
`ifdef VDC_ARB_STATS_EN
    input  logic                            stat_clr,
    output logic [NREQ:0][15:0]             stat_cnt,
`endif
    output logic                            init_busy
);

    localparam logic [ADDR_BITS-1:0] DUMMY_ADDR = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    arbState_t               r_state, w_state_nxt;
    logic [NREQ-1:0]         r_grant, r_done, w_grant_nxt, w_done_nxt;
    logic [7:0]              r_rdata, r_ram_di, w_rdata_nxt, w_di_nxt;
    logic                    r_ram_rd, r_ram_we, w_rd_nxt, w_we_nxt, r_init_busy;
    logic [ADDR_BITS-1:0]    r_ram_addr, w_addr_nxt, r_init_addr, w_init_addr_nxt;
    logic [7:0]              r_starve, w_starve_nxt;

    logic                    w_slot_start, w_slot_end, w_force_cpu, w_win_any;
    logic [NREQ-1:0]         w_mask, w_cand, w_grant_sel;
    logic [IDX_W-1:0]        w_win_idx;

    assign w_slot_start = enable && newCol && (r_state != ARB_INIT);
    assign w_slot_end   = enable && endCol && (r_state == ARB_ISSUED);

    // Window mask: refresh needs its window outside blanking; screen/attr fetches stop during blanking.
    always_comb begin
        w_mask           = '0;
        w_mask[REQ_CHAR] = 1'b1;
        w_mask[REQ_RFSH] = win_rfsh & ~win_int;
        w_mask[REQ_SCRN] = ~win_int;
        w_mask[REQ_ATTR] = ~win_int;
        w_mask[REQ_CPU]  = 1'b1;
    end

    assign w_cand      = req & w_mask;
    // A starving CPU overrides everything except a character fetch.
    assign w_force_cpu = (STARVE_LIMIT != 0) && (32'(r_starve) >= STARVE_LIMIT)
                         && req[REQ_CPU] && !req[REQ_CHAR];

    // Lowest-index-wins priority encoder; scanning downward leaves the lowest set index.
    always_comb begin
        w_win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_win_idx = w_cand[i] ? IDX_W'(i) : w_win_idx;
        end
        w_win_idx = w_force_cpu ? IDX_W'(REQ_CPU) : w_win_idx;
        w_win_any = w_force_cpu | (|w_cand);
    end

    assign w_grant_sel = w_win_any ? (NREQ'(1'b1) << w_win_idx) : '0;

    // State register; initRam chooses between the sweep and normal operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= initRam ? ARB_INIT : ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a newCol while ISSUED abandons the open slot and re-issues.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_INIT:   w_state_nxt = (&r_init_addr) ? ARB_IDLE : ARB_INIT;
            ARB_IDLE:   w_state_nxt = w_slot_start ? ARB_ISSUED : ARB_IDLE;
            ARB_ISSUED: begin
                if (w_slot_start) begin
                    w_state_nxt = ARB_ISSUED;
                end else if (w_slot_end) begin
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_state_nxt = ARB_ISSUED;
                end
            end
            default:    w_state_nxt = ARB_IDLE;
        endcase
    end

    // Output logic: completion is evaluated before the issue so a same-clk end+start yields done and a new grant.
    always_comb begin
        w_grant_nxt     = r_grant;
        w_done_nxt      = '0;
        w_rdata_nxt     = r_rdata;
        w_rd_nxt        = 1'b0;
        w_we_nxt        = 1'b0;
        w_addr_nxt      = r_ram_addr;
        w_di_nxt        = r_ram_di;
        w_starve_nxt    = r_starve;
        w_init_addr_nxt = r_init_addr;
        if (r_state == ARB_INIT) begin
            w_we_nxt        = 1'b1;
            w_addr_nxt      = r_init_addr;
            w_di_nxt        = init_data(r_init_addr[0]);
            w_init_addr_nxt = r_init_addr + ADDR_ONE;
        end else begin
            if (w_slot_end) begin
                w_rdata_nxt = ram_do;
                w_done_nxt  = r_grant;
                w_grant_nxt = '0;
            end else begin
                w_rdata_nxt = r_rdata;
            end
            if (w_slot_start) begin
                w_grant_nxt = w_grant_sel;
                if (w_win_any) begin
                    w_addr_nxt = req_addr[w_win_idx];
                    w_we_nxt   = req_we[w_win_idx];
                    w_rd_nxt   = ~req_we[w_win_idx];
                    w_di_nxt   = req_we[w_win_idx] ? req_wdata[w_win_idx] : r_ram_di;
                end else begin
                    w_addr_nxt = DUMMY_ADDR;
                    w_rd_nxt   = 1'b1;
                end
                if (req[REQ_CPU]) begin
                    if (w_grant_sel[REQ_CPU]) begin
                        w_starve_nxt = 8'd0;
                    end else begin
                        w_starve_nxt = (r_starve == STARVE_MAX) ? r_starve : r_starve + 8'd1;
                    end
                end else begin
                    w_starve_nxt = r_starve;
                end
            end else begin
                w_starve_nxt = r_starve;
            end
        end
    end

    // Output and datapath registers; reset drops any open slot without completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= '0;
            r_done      <= '0;
            r_rdata     <= 8'h00;
            r_ram_rd    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= DUMMY_ADDR;
            r_ram_di    <= 8'h00;
            r_starve    <= 8'd0;
            r_init_addr <= '0;
            r_init_busy <= 1'b1;
        end else begin
            r_grant     <= w_grant_nxt;
            r_done      <= w_done_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ram_rd    <= w_rd_nxt;
            r_ram_we    <= w_we_nxt;
            r_ram_addr  <= w_addr_nxt;
            r_ram_di    <= w_di_nxt;
            r_starve    <= w_starve_nxt;
            r_init_addr <= w_init_addr_nxt;
            r_init_busy <= (r_state == ARB_INIT);
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign ram_rd    = r_ram_rd;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_di    = r_ram_di;
    assign init_busy = r_init_busy;

`ifdef VDC_ARB_STATS_EN
    vdc_arb_stats u_stats (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (stat_clr),
        .i_slot     (w_slot_start),
        .i_grant_oh (w_grant_sel),
        .o_cnt      (stat_cnt)
    );
`endif

endmodule

// File: tb/tb_vdc_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vdc_ram_arbiter
// Scoreboard bench for vdc_ram_arbiter (STARVE_LIMIT = 3). The stimulus side
// predicts each slot-level outcome from a slot model (priority list, windows,
// starvation count) and queues it; a monitor on the falling edge pops and
// compares whenever the DUT shows a RAM strobe or a done pulse. Point checks
// (reset values, init_busy timing) are queued to the same monitor.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vdc_ram_arbiter;

    logic              clk = 1'b0;
    logic              reset, enable, newCol, endCol, initRam, win_int, win_rfsh;
    logic [4:0]        req, req_we;
    logic [4:0][15:0]  req_addr;
    logic [4:0][7:0]   req_wdata;
    logic [4:0]        grant, done;
    logic [7:0]        rdata, ram_di, ram_do;
    logic              ram_rd, ram_we, init_busy;
    logic [15:0]       ram_addr;

    vdc_ram_arbiter #(.ADDR_BITS(16), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .newCol(newCol), .endCol(endCol),
        .initRam(initRam), .win_int(win_int), .win_rfsh(win_rfsh),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rdata(rdata), .ram_rd(ram_rd), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  grant;
        logic [4:0]  done;
        logic        rd;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  di;
        logic [7:0]  rdata;
    } rec_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    rec_t exp_q[$];
    chk_t chk_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;

    // slot model state
    bit         slot_open;
    int         owner;
    int         starve;
    logic [7:0] di_h, rdata_h;
    logic [4:0] last_done;

    function automatic logic [4:0] onehot(input int i);
        return 5'(1) << i;
    endfunction

    // Priority list in plain words: CHAR always first, then a starving CPU,
    // then refresh (its window, not blanking), screen, attribute, CPU.
    function automatic int pick(input logic [4:0] r, input logic wi, input logic wr, input int st);
        if (r[0]) return 0;
        if (st >= 3 && r[4]) return 4;
        if (r[1] && wr && !wi) return 1;
        if (r[2] && !wi) return 2;
        if (r[3] && !wi) return 3;
        if (r[4]) return 4;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name; c.act = act; c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"},  32'(grant),    32'h0);
        chk({tag, "_done"},   32'(done),     32'h0);
        chk({tag, "_rdata"},  32'(rdata),    32'h0);
        chk({tag, "_ram_rd"}, 32'(ram_rd),   32'h0);
        chk({tag, "_ram_we"}, 32'(ram_we),   32'h0);
        chk({tag, "_addr"},   32'(ram_addr), 32'hFFFF);
        chk({tag, "_di"},     32'(ram_di),   32'h0);
        chk({tag, "_busy"},   32'(init_busy), 32'h1);
    endtask

    // One clock with synchronous reset high; mid_end also drives an endCol into it.
    task automatic do_reset(input bit init, input bit mid_end, input string tag);
        reset = 1'b1; initRam = init;
        enable = mid_end; endCol = mid_end; newCol = 1'b0;
        @(posedge clk); #1;
        mon_on = 1'b1;
        chk_reset_vals(tag);
        reset = 1'b0; enable = 1'b0; endCol = 1'b0; req = '0;
        slot_open = 1'b0; owner = -1; starve = 0; di_h = 8'h00; rdata_h = 8'h00; last_done = '0;
    endtask

    // Drive one clock of slot controls and queue what the slot model predicts for it.
    task automatic step(input bit en, input bit nc, input bit ec);
        rec_t e;
        bit   e_end, e_start;
        int   w;
        enable = en; newCol = nc; endCol = ec; ram_do = 8'($urandom);
        e_end   = en && ec && slot_open;
        e_start = en && nc;
        e = '0;
        e.done = (e_end && owner >= 0) ? onehot(owner) : 5'd0;
        if (e_end) rdata_h = ram_do;
        if (e_start) begin
            w = pick(req, win_int, win_rfsh, starve);
            if (req[4]) starve = (w == 4) ? 0 : ((starve < 255) ? starve + 1 : 255);
            if (w >= 0) begin
                e.grant = onehot(w);
                e.we    = req_we[w];
                e.rd    = !req_we[w];
                e.addr  = req_addr[w];
                if (req_we[w]) di_h = req_wdata[w];
            end else begin
                e.rd   = 1'b1;
                e.addr = 16'hFFFF;
            end
            slot_open = 1'b1; owner = w;
        end else if (e_end) begin
            slot_open = 1'b0; owner = -1;
        end
        e.di = di_h; e.rdata = rdata_h;
        if (e_start || e.done != 5'd0) exp_q.push_back(e);
        last_done = e.done;
        @(posedge clk); #1;
    endtask

    // Monitor: evaluate queued point checks, then compare each visible slot output with the scoreboard.
    rec_t got, want;
    chk_t c;
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
            end
        end
        if (mon_on && (ram_rd || ram_we || (|done))) begin
            n_checks++;
            got = {grant, done, ram_rd, ram_we, ram_addr, ram_di, rdata};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_slot_output: got %h expected none at %0t", got, $time);
            end else begin
                want = exp_q.pop_front();
                if (!(want.rd || want.we)) begin
                    got.addr = 16'h0; want.addr = 16'h0;
                end
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL slot_output: got g=%b d=%b rd=%b we=%b a=%h di=%h rdata=%h expected g=%b d=%b rd=%b we=%b a=%h di=%h rdata=%h at %0t",
                             got.grant, got.done, got.rd, got.we, got.addr, got.di, got.rdata,
                             want.grant, want.done, want.rd, want.we, want.addr, want.di, want.rdata, $time);
                end
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t ir;
        reset = 1'b1; enable = 1'b0; newCol = 1'b0; endCol = 1'b0; initRam = 1'b1;
        win_int = 1'b0; win_rfsh = 1'b0; req = '0; req_we = '0; ram_do = 8'h00;
        for (int i = 0; i < 5; i++) begin
            req_addr[i]  = 16'($urandom);
            req_wdata[i] = 8'($urandom);
        end

        // 1: power-on init sweep; requests and slot pulses are ignored meanwhile
        do_reset(1'b1, 1'b0, "reset_init");
        for (int a = 0; a < 65536; a++) begin
            ir = '0;
            ir.we   = 1'b1;
            ir.addr = 16'(a);
            ir.di   = (a % 2 == 0) ? 8'hFF : 8'h00;
            exp_q.push_back(ir);
        end
        enable = 1'b1; newCol = 1'b1; endCol = 1'b1; req = '1;
        repeat (100) @(posedge clk);
        #1; newCol = 1'b0; endCol = 1'b0; req = '0;
        repeat (65436) @(posedge clk);
        #1;
        chk("init_busy_at_last_write", 32'(init_busy), 32'h1);
        @(posedge clk); #1;
        chk("init_busy_fall", 32'(init_busy), 32'h0);
        chk("init_we_off", 32'(ram_we), 32'h0);

        // reset without init: busy falls the first clock
        do_reset(1'b0, 1'b0, "reset_noinit");
        step(1'b0, 1'b0, 1'b0);
        chk("noinit_busy_fall", 32'(init_busy), 32'h0);

        // 2: CHAR wins over SCRN and CPU
        req_we = '0; win_int = 1'b0; win_rfsh = 1'b0;
        req = 5'b10101;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
        // 3: blanking masks SCRN/ATTR (dummy read), CPU still granted
        req = 5'b01100; win_int = 1'b1;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
        req = 5'b10000;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
        // 4: refresh window selects RFSH (a write) vs SCRN
        win_int = 1'b0; req = 5'b00110; req_we[1] = 1'b1; req_wdata[1] = 8'hA5;
        win_rfsh = 1'b1;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
        win_rfsh = 1'b0;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
        // enable low: slot pulses ignored
        step(1'b0, 1'b1, 1'b1);
        req = '0; req_we = '0;

        // 5: starvation guard, then CHAR blocks the forced grant
        do_reset(1'b0, 1'b0, "reset_starve");
        req = 5'b10100; win_int = 1'b0;
        repeat (4) begin step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1); end
        repeat (5) step(1'b1, 1'b1, 1'b1);
        req = 5'b10101;
        repeat (6) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        // abandoned slot: second newCol without endCol
        req = 5'b00100;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b1);
        req = '0;

        // randomized traffic honouring the requester hold rule
        for (int n = 0; n < 4000; n++) begin
            win_int  = ($urandom_range(3, 0) == 0);
            win_rfsh = $urandom_range(1, 0);
            step($urandom_range(7, 0) != 0, $urandom_range(2, 0) == 0, $urandom_range(2, 0) == 0);
            for (int i = 0; i < 5; i++) begin
                if (last_done[i] && $urandom_range(1, 0) == 1) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i]       = 1'b1;
                    req_we[i]    = $urandom_range(1, 0);
                    req_addr[i]  = 16'($urandom);
                    req_wdata[i] = 8'($urandom);
                end
            end
        end

        // 6: reset between newCol and endCol: no completion, reset values next clock
        do_reset(1'b0, 1'b0, "reset_pre6");
        req = 5'b00100; req_we = '0; win_int = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        req = 5'b00100;
        do_reset(1'b0, 1'b1, "reset_midslot");
        req = 5'b00100;
        step(1'b1, 1'b0, 1'b1);
        chk("midslot_no_done", 32'(done), 32'h0);
        req = '0;
        repeat (3) step(1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
